ccd_hclk_pattern_gen: RTL and testbench



---
 rtl/ccd_hclk_pattern_gen.sv | 142 ++++++++++++++
 tb/tb_ccd_hclk_pattern_gen.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ccd_hclk_pattern_gen.sv
// ccd_hclk_pattern_gen: CCD horizontal clock pattern generator with shadowed config, binning and line counting
module ccd_hclk_pattern_gen #(
  parameter int NUM_PHASES = 6,
  parameter int PAT_LEN = 16,
  parameter int SLOT_W = $clog2(PAT_LEN),
  parameter int PIX_W = 12,
  parameter int CFG_AW = 5
) (
  input  logic                  CLK_SYS,
  input  logic                  RST,
  input  logic                  run,
  input  logic                  cfg_we,
  input  logic [CFG_AW-1:0]     cfg_addr,
  input  logic [PAT_LEN-1:0]    cfg_wdata,
  output logic [NUM_PHASES-1:0] phase_out,
  output logic                  pixel_tick,
  output logic [SLOT_W-1:0]     slot_cnt,
  output logic [PIX_W-1:0]      pix_cnt,
  output logic                  line_done,
  output logic                  busy,
  output logic                  cfg_err
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic [SLOT_W-1:0] LAST = SLOT_W'(PAT_LEN - 1);
  state_t state_q, state_d;
  logic [PAT_LEN-1:0] pat_q [NUM_PHASES];
  logic [PAT_LEN-1:0] sh_pat_q [NUM_PHASES];
  logic [PAT_LEN-1:0] sh_pat_d [NUM_PHASES];
  logic [NUM_PHASES-1:0] idle_q, mask_q, sh_idle_q, sh_idle_d, sh_mask_q, sh_mask_d;
  logic [3:0] b_q, sh_b_q, sh_b_d, b_eff;
  logic [PIX_W-1:0] len_q, sh_len_q, sh_len_d;
  logic first_q, first_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic [3:0] bin_q, bin_d;
  logic [NUM_PHASES-1:0] phase_q, phase_d;
  logic tick_q, tick_d, done_q, done_d, err_q;
  logic last, load, gen, line_end;
  always_ff @(posedge CLK_SYS) begin
    if (RST) begin
      for (int k = 0; k < NUM_PHASES; k++) pat_q[k] <= '0;
      idle_q <= '0;
      mask_q <= '0;
      b_q <= 4'd1;
      len_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (cfg_we) begin
        for (int k = 0; k < NUM_PHASES; k++)
          if (cfg_addr == CFG_AW'(k)) pat_q[k] <= cfg_wdata;
        if (cfg_addr == CFG_AW'(NUM_PHASES)) idle_q <= NUM_PHASES'(cfg_wdata);
        if (cfg_addr == CFG_AW'(NUM_PHASES + 1)) mask_q <= NUM_PHASES'(cfg_wdata);
        if (cfg_addr == CFG_AW'(NUM_PHASES + 2)) b_q <= 4'(cfg_wdata);
        if (cfg_addr == CFG_AW'(NUM_PHASES + 3)) len_q <= PIX_W'(cfg_wdata);
        if (int'(cfg_addr) >= NUM_PHASES + 4) err_q <= 1'b1;
      end
    end
  end
  // Phase levels are computed from the next slot/bin and the next shadow so the
  // freshly loaded bank is already visible on slot 0 of the new pixel.
  always_comb begin
    last = slot_q == LAST;
    load = (state_q == IDLE) ? run : (!first_q && last);
    for (int k = 0; k < NUM_PHASES; k++) sh_pat_d[k] = load ? pat_q[k] : sh_pat_q[k];
    sh_idle_d = load ? idle_q : sh_idle_q;
    sh_mask_d = load ? mask_q : sh_mask_q;
    sh_b_d = load ? b_q : sh_b_q;
    sh_len_d = load ? len_q : sh_len_q;
    b_eff = (sh_b_d == 4'd0) ? 4'd1 : sh_b_d;
    line_end = (sh_len_q != '0) && (pix_q == sh_len_q - PIX_W'(1));
    state_d = state_q;
    first_d = 1'b0;
    slot_d = '0;
    tick_d = 1'b0;
    pix_d = '0;
    bin_d = 4'd0;
    done_d = 1'b0;
    gen = 1'b0;
    if (state_q == IDLE) begin
      state_d = run ? RUN : IDLE;
      first_d = run;
    end else if (first_q) begin
      gen = 1'b1;
      tick_d = 1'b1;
    end else if (!last) begin
      gen = 1'b1;
      slot_d = slot_q + SLOT_W'(1);
      pix_d = pix_q;
      bin_d = bin_q;
      done_d = (slot_d == LAST) && line_end;
    end else if (!run) begin
      state_d = IDLE;
    end else begin
      gen = 1'b1;
      tick_d = 1'b1;
      pix_d = line_end ? '0 : pix_q + PIX_W'(1);
      bin_d = (line_end || sh_b_d != sh_b_q || bin_q == b_eff - 4'd1) ? 4'd0 : bin_q + 4'd1;
    end
    phase_d = sh_idle_d;
    for (int k = 0; k < NUM_PHASES; k++)
      if (gen && !(sh_mask_d[k] && bin_d != b_eff - 4'd1)) phase_d[k] = sh_pat_d[k][LAST - slot_d];
  end
  always_ff @(posedge CLK_SYS) begin
    if (RST) begin
      state_q <= IDLE;
      for (int k = 0; k < NUM_PHASES; k++) sh_pat_q[k] <= '0;
      sh_idle_q <= '0;
      sh_mask_q <= '0;
      sh_b_q <= 4'd1;
      sh_len_q <= '0;
      first_q <= 1'b0;
      slot_q <= '0;
      pix_q <= '0;
      bin_q <= 4'd0;
      phase_q <= '0;
      tick_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      for (int k = 0; k < NUM_PHASES; k++) sh_pat_q[k] <= sh_pat_d[k];
      sh_idle_q <= sh_idle_d;
      sh_mask_q <= sh_mask_d;
      sh_b_q <= sh_b_d;
      sh_len_q <= sh_len_d;
      first_q <= first_d;
      slot_q <= slot_d;
      pix_q <= pix_d;
      bin_q <= bin_d;
      phase_q <= phase_d;
      tick_q <= tick_d;
      done_q <= done_d;
    end
  end
  assign phase_out = phase_q;
  assign pixel_tick = tick_q;
  assign slot_cnt = slot_q;
  assign pix_cnt = pix_q;
  assign line_done = done_q;
  assign busy = state_q == RUN;
  assign cfg_err = err_q;
endmodule

// File: tb/tb_ccd_hclk_pattern_gen.sv
// tb_ccd_hclk_pattern_gen: directed self-checking bench for ccd_hclk_pattern_gen
module tb_ccd_hclk_pattern_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run = 1'b0;
  logic cfg_we = 1'b0;
  logic [4:0] cfg_addr = '0;
  logic [15:0] cfg_wdata = '0;
  logic [5:0] phase_out;
  logic pixel_tick;
  logic [3:0] slot_cnt;
  logic [11:0] pix_cnt;
  logic line_done, busy, cfg_err;
  int n_tests = 0;
  int n_fail = 0;
  logic [15:0] pat0;
  ccd_hclk_pattern_gen dut (
    .CLK_SYS(clk), .RST(rst), .run(run), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .phase_out(phase_out), .pixel_tick(pixel_tick),
    .slot_cnt(slot_cnt), .pix_cnt(pix_cnt), .line_done(line_done), .busy(busy), .cfg_err(cfg_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic cfg_write(input logic [4:0] a, input logic [15:0] d);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask
  task automatic goto_slot(input int s);
    int n = 0;
    do begin
      tick();
      n++;
    end while (32'(slot_cnt) != s && n < 64);
    check("goto_slot", 32'(slot_cnt), s);
  endtask
  task automatic check_reset(input string tag);
    check({tag, "_phase"}, 32'(phase_out), 0);
    check({tag, "_tick"}, 32'(pixel_tick), 0);
    check({tag, "_slot"}, 32'(slot_cnt), 0);
    check({tag, "_pix"}, 32'(pix_cnt), 0);
    check({tag, "_done"}, 32'(line_done), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_err"}, 32'(cfg_err), 0);
  endtask
  initial begin
    pat0 = 16'h80FF;
    repeat (2) tick();
    check_reset("rst");
    rst = 1'b0;
    // basic pattern, start latency
    cfg_write(5'd0, 16'h80FF);
    cfg_write(5'd6, 16'h0001);
    check("idle_before_run", 32'(phase_out), 0);
    run = 1'b1;
    tick();
    check("start_tick_early", 32'(pixel_tick), 0);
    check("start_busy", 32'(busy), 1);
    check("start_idle_lvl", 32'(phase_out), 1);
    tick();
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < 16; s++) begin
        check("pat_slot", 32'(slot_cnt), s);
        check("pat_phase", 32'(phase_out), 32'(pat0[15-s]));
        check("pat_tick", 32'(pixel_tick), 32'(s == 0));
        check("pat_pix", 32'(pix_cnt), p);
        tick();
      end
    // boundary reload: mid-pixel write, then a write in the last slot
    goto_slot(5);
    cfg_write(5'd1, 16'hF800);
    goto_slot(15);
    check("reload_old", 32'(phase_out[1]), 0);
    goto_slot(0);
    check("reload_pix", 32'(pix_cnt), 3);
    check("reload_new_s0", 32'(phase_out[1]), 1);
    goto_slot(4);
    check("reload_new_s4", 32'(phase_out[1]), 1);
    goto_slot(5);
    check("reload_new_s5", 32'(phase_out[1]), 0);
    goto_slot(15);
    cfg_write(5'd1, 16'h0001);
    check("late_miss_s0", 32'(phase_out[1]), 1);
    goto_slot(15);
    check("late_miss_s15", 32'(phase_out[1]), 0);
    goto_slot(0);
    check("late_new_s0", 32'(phase_out[1]), 0);
    goto_slot(15);
    check("late_new_s15", 32'(phase_out[1]), 1);
    // binning B=3 with phase 3 masked
    goto_slot(3);
    cfg_write(5'd3, 16'h2000);
    cfg_write(5'd7, 16'h0008);
    cfg_write(5'd8, 16'h0003);
    for (int p = 0; p < 6; p++) begin
      goto_slot(0);
      check("bin_ph0", 32'(phase_out[0]), 1);
      goto_slot(2);
      check("bin_ph3", 32'(phase_out[3]), 32'(p % 3 == 2));
    end
    // stop at slot 7: pixel completes, then idle
    goto_slot(7);
    run = 1'b0;
    goto_slot(15);
    check("stop_busy_hold", 32'(busy), 1);
    tick();
    check("stop_busy", 32'(busy), 0);
    check("stop_idle", 32'(phase_out), 1);
    check("stop_pix", 32'(pix_cnt), 0);
    check("stop_slot", 32'(slot_cnt), 0);
    check("stop_tick", 32'(pixel_tick), 0);
    cfg_write(5'd7, 16'h0000);
    cfg_write(5'd8, 16'h0001);
    cfg_write(5'd9, 16'h0004);
    run = 1'b1;
    tick();
    check("restart_tick_early", 32'(pixel_tick), 0);
    tick();
    check("restart_tick", 32'(pixel_tick), 1);
    check("restart_slot", 32'(slot_cnt), 0);
    // line length 4
    for (int p = 0; p < 12; p++) begin
      check("line_pix", 32'(pix_cnt), p % 4);
      goto_slot(14);
      check("line_done_s14", 32'(line_done), 0);
      goto_slot(15);
      check("line_done_s15", 32'(line_done), 32'(p % 4 == 3));
      goto_slot(0);
    end
    // reset mid-pixel
    goto_slot(9);
    rst = 1'b1;
    run = 1'b0;
    tick();
    check_reset("midrst");
    rst = 1'b0;
    // unmapped address and B=0
    cfg_write(5'd10, 16'hFFFF);
    check("err_pulse", 32'(cfg_err), 1);
    tick();
    check("err_clear", 32'(cfg_err), 0);
    cfg_write(5'd2, 16'h4000);
    check("err_valid", 32'(cfg_err), 0);
    cfg_write(5'd7, 16'h0004);
    cfg_write(5'd8, 16'h0000);
    run = 1'b1;
    tick();
    tick();
    check("b0_s0", 32'(phase_out), 0);
    for (int p = 0; p < 3; p++) begin
      goto_slot(1);
      check("b0_ph2", 32'(phase_out), 32'h4);
      goto_slot(8);
      check("b0_s8", 32'(phase_out), 0);
    end
    run = 1'b0;
    for (int n = 0; n < 40 && busy; n++) tick();
    check("final_idle", 32'(busy), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
